// File: rtl/cp0_tlb_gen.sv
// MIPS CP0 register file with TLB support registers (Index/Random/EntryHi/EntryLo/Context/Wired).
// Reads and w_index/int_req are combinational from state; there is no backpressure, and updates land on the next rising clk edge.
module cp0_tlb_gen #(
  parameter int TLBNUM    = 16,
  parameter int COUNT_DIV = 2,
  localparam int IDXW     = $clog2(TLBNUM)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_ex,
  input  logic            wb_bd,
  input  logic            ws_eret,
  input  logic [4:0]      wb_excode,
  input  logic [31:0]     wb_pc,
  input  logic [31:0]     wb_badvaddr,
  input  logic [5:0]      ext_int_in,
  input  logic [7:0]      cp0_addr,
  input  logic            mtc0_we,
  input  logic [31:0]     cp0_wdata,
  output logic [31:0]     cp0_rdata,
  input  logic            tlbp,
  input  logic            tlbr,
  input  logic            tlbwi,
  input  logic            tlbwr,
  input  logic            s1_found,
  input  logic [IDXW-1:0] s1_index,
  input  logic [18:0]     r_vpn2,
  input  logic [7:0]      r_asid,
  input  logic            r_g,
  input  logic [25:0]     r_lo0,
  input  logic [25:0]     r_lo1,
  output logic [31:0]     cp0_status,
  output logic [31:0]     cp0_cause,
  output logic [31:0]     cp0_epc,
  output logic [31:0]     cp0_entryhi,
  output logic [31:0]     cp0_entrylo0,
  output logic [31:0]     cp0_entrylo1,
  output logic [31:0]     cp0_index,
  output logic [IDXW-1:0] w_index,
  output logic            int_req
);

  localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [IDXW-1:0] TOP = IDXW'(TLBNUM - 1);

  logic [7:0]      status_im;
  logic            status_ie, status_exl;
  logic            cause_bd, cause_ti;
  logic [1:0]      cause_ip_sw;
  logic [7:2]      cause_ip_hw;
  logic [4:0]      cause_excode;
  logic [31:0]     epc, badvaddr, count, compare;
  logic [PW-1:0]   prescaler;
  logic [IDXW-1:0] wired, random;
  logic [8:0]      ctx_ptebase;
  logic [18:0]     ctx_badvpn2;
  logic [18:0]     eh_vpn2;
  logic [7:0]      eh_asid;
  logic [25:0]     lo0, lo1;
  logic            index_p;
  logic [IDXW-1:0] index_idx;

  logic wr_index, wr_lo0, wr_lo1, wr_context, wr_wired, wr_count;
  logic wr_entryhi, wr_compare, wr_status, wr_cause, wr_epc;
  logic tlb_exc, addr_exc;
  logic unused_lo_msb;

  assign wr_index   = mtc0_we && (cp0_addr == 8'h00);
  assign wr_lo0     = mtc0_we && (cp0_addr == 8'h10);
  assign wr_lo1     = mtc0_we && (cp0_addr == 8'h18);
  assign wr_context = mtc0_we && (cp0_addr == 8'h20);
  assign wr_wired   = mtc0_we && (cp0_addr == 8'h30);
  assign wr_count   = mtc0_we && (cp0_addr == 8'h48);
  assign wr_entryhi = mtc0_we && (cp0_addr == 8'h50);
  assign wr_compare = mtc0_we && (cp0_addr == 8'h58);
  assign wr_status  = mtc0_we && (cp0_addr == 8'h60);
  assign wr_cause   = mtc0_we && (cp0_addr == 8'h68);
  assign wr_epc     = mtc0_we && (cp0_addr == 8'h70);

  // TLB refill/invalid/modified exceptions capture the VPN; address errors only BadVAddr
  assign tlb_exc  = wb_ex && (wb_excode >= 5'd1) && (wb_excode <= 5'd3);
  assign addr_exc = wb_ex && (wb_excode >= 5'd1) && (wb_excode <= 5'd5);

  // The TLB read port supplies {pfn,c,d,v} in its low 25 bits; the top bit carries nothing
  assign unused_lo_msb = &{1'b0, r_lo0[25], r_lo1[25]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_im  <= '0;
      status_ie  <= 1'b0;
      status_exl <= 1'b0;
    end else begin
      if (wr_status) begin
        status_im <= cp0_wdata[15:8];
        status_ie <= cp0_wdata[0];
      end
      if (wb_ex)          status_exl <= 1'b1;
      else if (ws_eret)   status_exl <= 1'b0;
      else if (wr_status) status_exl <= cp0_wdata[1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cause_bd     <= 1'b0;
      cause_ti     <= 1'b0;
      cause_ip_sw  <= '0;
      cause_ip_hw  <= '0;
      cause_excode <= '0;
    end else begin
      cause_ip_hw <= {ext_int_in[5] | cause_ti, ext_int_in[4:0]};
      if (wr_compare)             cause_ti <= 1'b0;
      else if (count == compare)  cause_ti <= 1'b1;
      if (wr_cause) cause_ip_sw <= cp0_wdata[9:8];
      if (wb_ex) begin
        cause_excode <= wb_excode;
        if (!status_exl) cause_bd <= wb_bd;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      epc      <= '0;
      badvaddr <= '0;
    end else begin
      if (wb_ex) begin
        if (!status_exl) epc <= wb_bd ? (wb_pc - 32'd4) : wb_pc;
      end else if (wr_epc) begin
        epc <= cp0_wdata;
      end
      if (addr_exc) badvaddr <= wb_badvaddr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      prescaler <= '0;
      compare   <= 32'hFFFF_FFFF;
    end else begin
      if (wr_count) begin
        count     <= cp0_wdata;
        prescaler <= '0;
      end else if (prescaler == PW'(COUNT_DIV - 1)) begin
        count     <= count + 32'd1;
        prescaler <= '0;
      end else begin
        prescaler <= prescaler + PW'(1);
      end
      if (wr_compare) compare <= cp0_wdata;
    end
  end

  // Random walks down from TOP to Wired and wraps; Wired at TOP pins it there
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wired  <= '0;
      random <= TOP;
    end else begin
      if (wr_wired) wired <= cp0_wdata[IDXW-1:0];
      if (wr_wired || (random <= wired)) random <= TOP;
      else                               random <= random - IDXW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctx_ptebase <= '0;
      ctx_badvpn2 <= '0;
      eh_vpn2     <= '0;
      eh_asid     <= '0;
    end else begin
      if (wr_context) ctx_ptebase <= cp0_wdata[31:23];
      if (tlb_exc)    ctx_badvpn2 <= wb_badvaddr[31:13];
      if (tlb_exc)         eh_vpn2 <= wb_badvaddr[31:13];
      else if (wr_entryhi) eh_vpn2 <= cp0_wdata[31:13];
      else if (tlbr)       eh_vpn2 <= r_vpn2;
      if (wr_entryhi) eh_asid <= cp0_wdata[7:0];
      else if (tlbr)  eh_asid <= r_asid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lo0       <= '0;
      lo1       <= '0;
      index_p   <= 1'b0;
      index_idx <= '0;
    end else begin
      if (wr_lo0)    lo0 <= cp0_wdata[25:0];
      else if (tlbr) lo0 <= {r_lo0[24:0], r_g};
      if (wr_lo1)    lo1 <= cp0_wdata[25:0];
      else if (tlbr) lo1 <= {r_lo1[24:0], r_g};
      if (tlbp) begin
        index_p   <= ~s1_found;
        index_idx <= s1_index;
      end else if (wr_index) begin
        index_idx <= cp0_wdata[IDXW-1:0];
      end
    end
  end

  logic [7:0]  cause_ip;
  logic [31:0] context_q;

  assign cause_ip     = {cause_ip_hw, cause_ip_sw};
  assign context_q    = {ctx_ptebase, ctx_badvpn2, 4'b0};
  assign cp0_status   = {9'b0, 1'b1, 6'b0, status_im, 6'b0, status_exl, status_ie};
  assign cp0_cause    = {cause_bd, cause_ti, 14'b0, cause_ip, 1'b0, cause_excode, 2'b0};
  assign cp0_epc      = epc;
  assign cp0_entryhi  = {eh_vpn2, 5'b0, eh_asid};
  assign cp0_entrylo0 = {6'b0, lo0};
  assign cp0_entrylo1 = {6'b0, lo1};
  assign cp0_index    = {index_p, {(31-IDXW){1'b0}}, index_idx};

  // tlbwi and idle both take the Index slot
  assign w_index = tlbwr ? random : index_idx;
  assign int_req = status_ie & ~status_exl & (|(cause_ip & status_im));

  always_comb begin
    cp0_rdata = '0;
    case (cp0_addr)
      8'h00: cp0_rdata = cp0_index;
      8'h08: cp0_rdata = {{(32-IDXW){1'b0}}, random};
      8'h10: cp0_rdata = cp0_entrylo0;
      8'h18: cp0_rdata = cp0_entrylo1;
      8'h20: cp0_rdata = context_q;
      8'h30: cp0_rdata = {{(32-IDXW){1'b0}}, wired};
      8'h40: cp0_rdata = badvaddr;
      8'h48: cp0_rdata = count;
      8'h50: cp0_rdata = cp0_entryhi;
      8'h58: cp0_rdata = compare;
      8'h60: cp0_rdata = cp0_status;
      8'h68: cp0_rdata = cp0_cause;
      8'h70: cp0_rdata = epc;
      default: cp0_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_tlb_gen.sv
// Randomized bench for cp0_tlb_gen against a word-level model of the CP0 registers.
module tb_cp0_tlb_gen;
  localparam int TLBNUM    = 16;
  localparam int COUNT_DIV = 2;
  localparam int IDXW      = 4;

  logic clk = 1'b0;
  logic rst;
  logic wb_ex, wb_bd, ws_eret;
  logic [4:0] wb_excode;
  logic [31:0] wb_pc, wb_badvaddr;
  logic [5:0] ext_int_in;
  logic [7:0] cp0_addr;
  logic mtc0_we;
  logic [31:0] cp0_wdata, cp0_rdata;
  logic tlbp, tlbr, tlbwi, tlbwr;
  logic s1_found;
  logic [IDXW-1:0] s1_index;
  logic [18:0] r_vpn2;
  logic [7:0] r_asid;
  logic r_g;
  logic [25:0] r_lo0, r_lo1;
  logic [31:0] cp0_status, cp0_cause, cp0_epc, cp0_entryhi, cp0_entrylo0, cp0_entrylo1, cp0_index;
  logic [IDXW-1:0] w_index;
  logic int_req;

  always #5 clk = ~clk;

  cp0_tlb_gen #(.TLBNUM(TLBNUM), .COUNT_DIV(COUNT_DIV)) dut (
    .clk(clk), .rst(rst), .wb_ex(wb_ex), .wb_bd(wb_bd), .ws_eret(ws_eret),
    .wb_excode(wb_excode), .wb_pc(wb_pc), .wb_badvaddr(wb_badvaddr), .ext_int_in(ext_int_in),
    .cp0_addr(cp0_addr), .mtc0_we(mtc0_we), .cp0_wdata(cp0_wdata), .cp0_rdata(cp0_rdata),
    .tlbp(tlbp), .tlbr(tlbr), .tlbwi(tlbwi), .tlbwr(tlbwr), .s1_found(s1_found), .s1_index(s1_index),
    .r_vpn2(r_vpn2), .r_asid(r_asid), .r_g(r_g), .r_lo0(r_lo0), .r_lo1(r_lo1),
    .cp0_status(cp0_status), .cp0_cause(cp0_cause), .cp0_epc(cp0_epc), .cp0_entryhi(cp0_entryhi),
    .cp0_entrylo0(cp0_entrylo0), .cp0_entrylo1(cp0_entrylo1), .cp0_index(cp0_index),
    .w_index(w_index), .int_req(int_req)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference state, kept as whole architectural words
  logic [31:0] m_status, m_cause, m_epc, m_badv, m_count, m_compare, m_context;
  logic [31:0] m_entryhi, m_lo0, m_lo1, m_index;
  int m_presc, m_wired, m_random;

  function automatic logic [31:0] m_read(input logic [7:0] a);
    case (a)
      8'h00: return m_index;
      8'h08: return 32'(m_random);
      8'h10: return m_lo0;
      8'h18: return m_lo1;
      8'h20: return m_context;
      8'h30: return 32'(m_wired);
      8'h40: return m_badv;
      8'h48: return m_count;
      8'h50: return m_entryhi;
      8'h58: return m_compare;
      8'h60: return m_status;
      8'h68: return m_cause;
      8'h70: return m_epc;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic m_int();
    return m_status[0] && !m_status[1] && ((m_cause[15:8] & m_status[15:8]) != 8'h0);
  endfunction

  task automatic model_reset();
    m_status = 32'h0040_0000; m_cause = 0; m_epc = 0; m_badv = 0; m_count = 0; m_presc = 0;
    m_compare = 32'hFFFF_FFFF; m_wired = 0; m_random = TLBNUM - 1; m_context = 0;
    m_entryhi = 0; m_lo0 = 0; m_lo1 = 0; m_index = 0;
  endtask

  task automatic model_step();
    logic [31:0] s, c, e, bv, cnt, cmp, ctx, eh, l0, l1, ix;
    int pr, wd, rn;
    logic exl, tlbx, adrx;
    s = m_status; c = m_cause; e = m_epc; bv = m_badv; cnt = m_count; cmp = m_compare;
    ctx = m_context; eh = m_entryhi; l0 = m_lo0; l1 = m_lo1; ix = m_index;
    pr = m_presc; wd = m_wired; rn = m_random;
    exl  = m_status[1];
    tlbx = wb_ex && wb_excode >= 1 && wb_excode <= 3;
    adrx = wb_ex && wb_excode >= 1 && wb_excode <= 5;
    if (mtc0_we && cp0_addr == 8'h60) s = 32'h0040_0000 | (cp0_wdata & 32'h0000_FF03);
    if (ws_eret) s[1] = 1'b0;
    if (wb_ex) s[1] = 1'b1;
    c[15:10] = {ext_int_in[5] | m_cause[30], ext_int_in[4:0]};
    if (mtc0_we && cp0_addr == 8'h68) c[9:8] = cp0_wdata[9:8];
    if (m_count == m_compare) c[30] = 1'b1;
    if (mtc0_we && cp0_addr == 8'h58) begin c[30] = 1'b0; cmp = cp0_wdata; end
    if (wb_ex) begin
      c[6:2] = wb_excode;
      if (!exl) c[31] = wb_bd;
    end
    if (wb_ex) begin
      if (!exl) e = wb_bd ? wb_pc - 32'd4 : wb_pc;
    end else if (mtc0_we && cp0_addr == 8'h70) e = cp0_wdata;
    if (adrx) bv = wb_badvaddr;
    if (mtc0_we && cp0_addr == 8'h48) begin cnt = cp0_wdata; pr = 0; end
    else if (m_presc == COUNT_DIV - 1) begin cnt = m_count + 1; pr = 0; end
    else pr = m_presc + 1;
    if (mtc0_we && cp0_addr == 8'h30) begin wd = int'(cp0_wdata % TLBNUM); rn = TLBNUM - 1; end
    else if (m_random <= m_wired) rn = TLBNUM - 1;
    else rn = m_random - 1;
    if (mtc0_we && cp0_addr == 8'h20) ctx = (ctx & 32'h007F_FFFF) | (cp0_wdata & 32'hFF80_0000);
    if (tlbx) ctx = (ctx & 32'hFF80_0000) | ((wb_badvaddr >> 13) << 4);
    if (tlbr) eh = {r_vpn2, 5'b0, r_asid};
    if (mtc0_we && cp0_addr == 8'h50) eh = cp0_wdata & 32'hFFFF_E0FF;
    if (tlbx) eh = (eh & 32'h0000_1FFF) | (wb_badvaddr & 32'hFFFF_E000);
    if (tlbr) begin
      l0 = {6'b0, r_lo0[24:0], r_g};
      l1 = {6'b0, r_lo1[24:0], r_g};
    end
    if (mtc0_we && cp0_addr == 8'h10) l0 = cp0_wdata & 32'h03FF_FFFF;
    if (mtc0_we && cp0_addr == 8'h18) l1 = cp0_wdata & 32'h03FF_FFFF;
    if (mtc0_we && cp0_addr == 8'h00) ix = (m_index & 32'h8000_0000) | (cp0_wdata % TLBNUM);
    if (tlbp) ix = {~s1_found, 27'b0, s1_index};
    m_status = s; m_cause = c; m_epc = e; m_badv = bv; m_count = cnt; m_compare = cmp;
    m_context = ctx; m_entryhi = eh; m_lo0 = l0; m_lo1 = l1; m_index = ix;
    m_presc = pr; m_wired = wd; m_random = rn;
  endtask

  task automatic check_all(input string ph);
    check_val({ph, ".status"}, cp0_status, m_status);
    check_val({ph, ".cause"}, cp0_cause, m_cause);
    check_val({ph, ".epc"}, cp0_epc, m_epc);
    check_val({ph, ".entryhi"}, cp0_entryhi, m_entryhi);
    check_val({ph, ".lo0"}, cp0_entrylo0, m_lo0);
    check_val({ph, ".lo1"}, cp0_entrylo1, m_lo1);
    check_val({ph, ".index"}, cp0_index, m_index);
    check_val({ph, ".rdata"}, cp0_rdata, m_read(cp0_addr));
    check_val({ph, ".w_index"}, 32'(w_index), tlbwr ? 32'(m_random) : (m_index % TLBNUM));
    check_val({ph, ".int_req"}, 32'(int_req), 32'(m_int()));
  endtask

  task automatic idle();
    wb_ex = 0; wb_bd = 0; ws_eret = 0; wb_excode = 0; wb_pc = 0; wb_badvaddr = 0;
    mtc0_we = 0; cp0_wdata = 0; tlbp = 0; tlbr = 0; tlbwi = 0; tlbwr = 0;
    s1_found = 0; s1_index = 0; r_vpn2 = 0; r_asid = 0; r_g = 0; r_lo0 = 0; r_lo1 = 0;
  endtask

  task automatic step(input string ph);
    @(posedge clk);
    model_step();
    #1;
    check_all(ph);
  endtask

  task automatic mtc0(input logic [7:0] a, input logic [31:0] d);
    idle();
    mtc0_we = 1; cp0_addr = a; cp0_wdata = d;
    step("mtc0");
    mtc0_we = 0;
  endtask

  logic [7:0] addr_tab [16] = '{8'h00, 8'h08, 8'h10, 8'h18, 8'h20, 8'h30, 8'h40, 8'h48,
                                8'h50, 8'h58, 8'h60, 8'h68, 8'h70, 8'h01, 8'h78, 8'h38};

  initial begin
    bit seen;
    rst = 1; idle(); ext_int_in = 0; cp0_addr = 8'h08;
    model_reset();
    #1;
    check_val("rst_status", cp0_status, 32'h0040_0000);
    check_val("rst_random", cp0_rdata, 32'd15);
    check_val("rst_index", cp0_index, 32'h0);
    check_val("rst_int_req", 32'(int_req), 32'h0);
    @(negedge clk); #2 rst = 0;

    // exception in a delay slot, then a nested one while EXL is set
    idle();
    wb_ex = 1; wb_bd = 1; wb_pc = 32'hBFC0_0104; wb_excode = 5'd2; wb_badvaddr = 32'h0040_2468;
    cp0_addr = 8'h20;
    step("exc1");
    check_val("exc_epc", cp0_epc, 32'hBFC0_0100);
    check_val("exc_cause", cp0_cause, 32'h8000_0008);
    check_val("exc_exl", 32'(cp0_status[1]), 32'h1);
    check_val("exc_vpn2", 32'(cp0_entryhi[31:13]), 32'h201);
    check_val("exc_context", cp0_rdata, 32'h0000_2010);
    idle(); wb_ex = 1; wb_pc = 32'h0;
    step("exc2");
    check_val("exc2_epc", cp0_epc, 32'hBFC0_0100);
    idle(); ws_eret = 1;
    step("eret");

    idle(); tlbp = 1; s1_found = 0; s1_index = 4'd5;
    step("tlbp0");
    check_val("tlbp_miss_p", 32'(cp0_index[31]), 32'h1);
    idle(); tlbp = 1; s1_found = 1; s1_index = 4'd7;
    step("tlbp1");
    check_val("tlbp_hit", cp0_index, 32'h0000_0007);

    idle(); tlbr = 1; r_vpn2 = 19'h12345; r_asid = 8'h3C; r_g = 1;
    r_lo0 = 26'($urandom); r_lo1 = 26'($urandom);
    step("tlbr");
    check_val("tlbr_entryhi", cp0_entryhi, 32'h2468_A03C);
    check_val("tlbr_lo0_g", 32'(cp0_entrylo0[0]), 32'h1);
    check_val("tlbr_lo1_g", 32'(cp0_entrylo1[0]), 32'h1);

    mtc0(8'h30, 32'd4);
    idle(); cp0_addr = 8'h08; #1;
    check_val("wired_random_top", cp0_rdata, 32'd15);
    for (int i = 0; i < 11; i++) step("rand_walk");
    check_val("random_at_wired", cp0_rdata, 32'd4);
    step("rand_wrap");
    check_val("random_wrapped", cp0_rdata, 32'd15);
    tlbwr = 1; #1;
    check_val("tlbwr_windex", 32'(w_index), 32'(m_random));
    step("tlbwr");
    tlbwr = 0; tlbwi = 1; #1;
    check_val("tlbwi_windex", 32'(w_index), 32'h7);
    tlbwi = 0;

    mtc0(8'h48, 32'd0);
    mtc0(8'h58, 32'd3);
    mtc0(8'h60, 32'h0040_8001);
    idle(); seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      step("timer_wait");
      seen = cp0_cause[30] && int_req;
    end
    check_val("timer_irq", 32'(seen), 32'h1);
    mtc0(8'h58, 32'h100);
    check_val("ti_cleared", 32'(cp0_cause[30]), 32'h0);
    step("ti_settle");
    check_val("irq_cleared", 32'(int_req), 32'h0);

    for (int n = 0; n < 3000; n++) begin
      idle();
      mtc0_we = ($urandom_range(3) == 0);
      cp0_addr = addr_tab[$urandom_range(15)];
      cp0_wdata = $urandom;
      if (cp0_addr == 8'h58 && $urandom_range(1) == 1) cp0_wdata = m_count + 32'($urandom_range(6));
      wb_ex = ($urandom_range(15) == 0); wb_bd = 1'($urandom);
      wb_excode = 5'($urandom_range(7)); wb_pc = $urandom; wb_badvaddr = $urandom;
      ws_eret = ($urandom_range(15) == 0);
      ext_int_in = ($urandom_range(7) == 0) ? 6'($urandom) : 6'h0;
      tlbp = ($urandom_range(7) == 0); tlbr = ($urandom_range(7) == 0);
      tlbwi = ($urandom_range(7) == 0); tlbwr = ($urandom_range(7) == 0);
      s1_found = 1'($urandom); s1_index = IDXW'($urandom);
      r_vpn2 = 19'($urandom); r_asid = 8'($urandom); r_g = 1'($urandom);
      r_lo0 = 26'($urandom); r_lo1 = 26'($urandom);
      step("rnd");
    end

    // reset in the middle of a cycle carrying strobes
    idle(); tlbp = 1; s1_found = 0; s1_index = 4'd9; wb_ex = 1; wb_excode = 5'd1;
    mtc0_we = 1; cp0_addr = 8'h60; cp0_wdata = 32'hFFFF_FFFF; ext_int_in = 6'h3F;
    #2 rst = 1;
    #1;
    check_val("mid_rst_status", cp0_status, 32'h0040_0000);
    check_val("mid_rst_cause", cp0_cause, 32'h0);
    check_val("mid_rst_index", cp0_index, 32'h0);
    check_val("mid_rst_epc", cp0_epc, 32'h0);
    model_reset();
    @(posedge clk); #1;
    check_all("in_rst");
    idle(); ext_int_in = 0;
    @(negedge clk); rst = 0;
    for (int i = 0; i < 4; i++) step("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
